// File: rtl/seg_scan_if.sv
// Display-bus observer interface: scanned seg/an lines in, decoded frames out.
interface seg_scan_if #(
    parameter int unsigned NDIG = 4
);
    logic              cs;
    logic [6:0]        seg;
    logic [NDIG-1:0]   an;
    logic [4*NDIG-1:0] bcd;
    logic              frame_valid;
    logic              seg_err;

    modport master (output cs, seg, an, input bcd, frame_valid, seg_err);
    modport slave  (input cs, seg, an, output bcd, frame_valid, seg_err);
endinterface

// File: rtl/seg_scan_to_bcd.sv
// Loop-back reader for a multiplexed 7-segment bus: synchronizes and filters the scan,
// decodes each digit to BCD and publishes complete frames with an error flag.
module seg_scan_to_bcd #(
    parameter int unsigned NDIG       = 4,
    parameter int unsigned STABLE_CYC = 4
) (
    input  logic     clk,
    input  logic     rst,
    seg_scan_if.slave bus
);
    localparam int unsigned SW = 7 + NDIG;
    localparam int unsigned CW = $clog2(STABLE_CYC + 1);
    localparam int unsigned BW = 4 * NDIG;

    typedef enum logic [1:0] {IDLE, SETTLE, CAPTURED} state_t;

    state_t          state, state_nxt;
    logic [SW-1:0]   sync1, sync2, prev;
    logic [CW-1:0]   cnt, cnt_nxt;
    logic [NDIG-1:0] seen, seen_nxt, inv, inv_nxt;
    logic [BW-1:0]   shadow, shadow_nxt;
    logic [6:0]      seg_s;
    logic [NDIG-1:0] an_s;
    logic [3:0]      dig_c;
    logic            bad_c, changed_c, capture_c, onehot_c, take_c, publish_c;

    assign seg_s     = sync2[SW-1 -: 7];
    assign an_s      = sync2[NDIG-1:0];
    assign changed_c = (sync2 != prev);
    assign onehot_c  = (an_s != '0) && ((an_s & (an_s - NDIG'(1))) == '0);
    assign take_c    = capture_c && onehot_c;
    assign publish_c = bus.cs && (seen == '1);

    // Segment pattern back to BCD; anything unrecognised is flagged
    always_comb begin
        dig_c = 4'hF;
        bad_c = 1'b0;
        case (seg_s)
            7'h7E: dig_c = 4'd0;
            7'h30: dig_c = 4'd1;
            7'h6D: dig_c = 4'd2;
            7'h79: dig_c = 4'd3;
            7'h33: dig_c = 4'd4;
            7'h5B: dig_c = 4'd5;
            7'h5F: dig_c = 4'd6;
            7'h70: dig_c = 4'd7;
            7'h7F: dig_c = 4'd8;
            7'h7B: dig_c = 4'd9;
            default: bad_c = 1'b1;
        endcase
    end

    // Settle FSM: capture fires once per stable value, in the cycle the count saturates
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        capture_c = 1'b0;
        if (!bus.cs) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
        end else begin
            case (state)
                IDLE: begin
                    state_nxt = SETTLE;
                    cnt_nxt   = '0;
                end
                SETTLE: begin
                    if (changed_c) begin
                        cnt_nxt = '0;
                    end else if (cnt == CW'(STABLE_CYC - 1)) begin
                        cnt_nxt   = CW'(STABLE_CYC);
                        capture_c = 1'b1;
                        state_nxt = CAPTURED;
                    end else begin
                        cnt_nxt = cnt + CW'(1);
                    end
                end
                CAPTURED: begin
                    if (changed_c) begin
                        state_nxt = SETTLE;
                        cnt_nxt   = '0;
                    end
                end
                default: begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end
            endcase
        end
    end

    // Frame assembly; a capture coinciding with publication lands in the fresh frame
    always_comb begin
        seen_nxt   = seen;
        inv_nxt    = inv;
        shadow_nxt = shadow;
        if (!bus.cs || publish_c) begin
            seen_nxt = '0;
            inv_nxt  = '0;
        end
        if (take_c) begin
            for (int i = 0; i < NDIG; i++) begin
                if (an_s[i]) begin
                    shadow_nxt[4*i +: 4] = dig_c;
                    seen_nxt[i]          = 1'b1;
                    inv_nxt[i]           = bad_c;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1           <= '0;
            sync2           <= '0;
            prev            <= '0;
            state           <= IDLE;
            cnt             <= '0;
            seen            <= '0;
            inv             <= '0;
            shadow          <= '0;
            bus.bcd         <= '0;
            bus.seg_err     <= 1'b0;
            bus.frame_valid <= 1'b0;
        end else begin
            sync1           <= {bus.seg, bus.an};
            sync2           <= sync1;
            prev            <= sync2;
            state           <= state_nxt;
            cnt             <= cnt_nxt;
            seen            <= seen_nxt;
            inv             <= inv_nxt;
            shadow          <= shadow_nxt;
            bus.frame_valid <= publish_c;
            if (publish_c) begin
                bus.bcd     <= shadow;
                bus.seg_err <= |inv;
            end
        end
    end
endmodule

// File: tb/tb_seg_scan_to_bcd.sv
// Scoreboard bench for seg_scan_to_bcd: directed scans push expected frames, a monitor checks them.
module tb_seg_scan_to_bcd;
    localparam int unsigned NDIG       = 4;
    localparam int unsigned STABLE_CYC = 4;

    typedef struct {
        logic [15:0] bcd;
        logic        err;
        int unsigned edge_no;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    int unsigned edges = 0;
    int          total = 0;
    int          bad = 0;
    int          nframes = 0;
    exp_t        sbq[$];

    seg_scan_if #(.NDIG(NDIG)) bus ();

    seg_scan_to_bcd #(.NDIG(NDIG), .STABLE_CYC(STABLE_CYC)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) edges <= edges + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h required %0h (edge %0d)", name, act, req, edges);
        end
    endtask

    // Apply one scan value for n samples; a frame-closing digit publishes 8 edges after it is set
    task automatic drive(input logic [6:0] s, input logic [3:0] a, input int n,
                         input bit last = 1'b0, input logic [15:0] eb = 16'h0,
                         input logic ee = 1'b0);
        @(posedge clk);
        #1;
        bus.seg = s;
        bus.an  = a;
        if (last) sbq.push_back('{eb, ee, edges + 8});
        repeat (n - 1) @(posedge clk);
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Monitor: every frame_valid pulse must match the head of the scoreboard
    always @(negedge clk) begin
        exp_t e;
        if (!rst && bus.frame_valid === 1'b1) begin
            nframes++;
            if (sbq.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_frame: got bcd=%h err=%b required no frame (edge %0d)",
                         bus.bcd, bus.seg_err, edges);
            end else begin
                e = sbq.pop_front();
                check("frame_bcd", 32'(bus.bcd), 32'(e.bcd));
                check("frame_err", 32'(bus.seg_err), 32'(e.err));
                check("frame_edge", edges, e.edge_no);
            end
        end
    end

    initial begin
        bus.cs  = 1'b0;
        bus.seg = 7'h00;
        bus.an  = 4'h0;
        rst     = 1'b1;
        idle_cycles(3);
        check("reset_bcd", 32'(bus.bcd), 32'h0);
        check("reset_err", 32'(bus.seg_err), 32'h0);
        check("reset_fv", 32'(bus.frame_valid), 32'h0);
        rst    = 1'b0;
        bus.cs = 1'b1;

        // all-zero inputs: an not one-hot, nothing captured
        idle_cycles(20);
        check("idle_bcd", 32'(bus.bcd), 32'h0);
        check("idle_err", 32'(bus.seg_err), 32'h0);
        check("idle_frames", 32'(nframes), 32'd0);

        // clean frame 4321
        drive(7'h30, 4'h1, 8);
        drive(7'h6D, 4'h2, 8);
        drive(7'h79, 4'h4, 8);
        drive(7'h33, 4'h8, 8, 1'b1, 16'h4321, 1'b0);

        // blank digit 2, then a clean frame clears the error
        drive(7'h30, 4'h1, 8);
        drive(7'h6D, 4'h2, 8);
        drive(7'h00, 4'h4, 8);
        drive(7'h33, 4'h8, 8, 1'b1, 16'h4F21, 1'b1);
        drive(7'h7E, 4'h1, 8);
        drive(7'h30, 4'h2, 8);
        drive(7'h6D, 4'h4, 8);
        drive(7'h79, 4'h8, 8, 1'b1, 16'h3210, 1'b0);
        drive(7'h00, 4'h0, 4);
        idle_cycles(1);
        check("hold_bcd", 32'(bus.bcd), 32'h3210);
        check("hold_err", 32'(bus.seg_err), 32'h0);
        check("frames_after_err", 32'(nframes), 32'd3);

        // glitching digit 0 must never be captured, so digits 1..3 cannot complete a frame
        for (int i = 0; i < 8; i++) begin
            drive(7'h7E, 4'h1, 2);
            drive(7'h7F, 4'h1, 1);
        end
        drive(7'h30, 4'h2, 8);
        drive(7'h6D, 4'h4, 8);
        drive(7'h79, 4'h8, 8);
        drive(7'h00, 4'h0, 4);
        idle_cycles(1);
        check("glitch_frames", 32'(nframes), 32'd3);
        bus.cs = 1'b0;
        idle_cycles(3);
        bus.cs = 1'b1;

        // recapture: invalid digit 0 overwritten by 5 before completion
        drive(7'h00, 4'h1, 8);
        drive(7'h5F, 4'h2, 8);
        drive(7'h5B, 4'h1, 8);
        drive(7'h70, 4'h4, 8);
        drive(7'h7B, 4'h8, 8, 1'b1, 16'h9765, 1'b0);
        drive(7'h00, 4'h0, 4);
        idle_cycles(1);
        check("recap_frames", 32'(nframes), 32'd4);

        // cs drop discards the partial frame
        drive(7'h30, 4'h1, 8);
        drive(7'h6D, 4'h2, 8);
        bus.cs = 1'b0;
        idle_cycles(5);
        check("cs_off_fv", 32'(bus.frame_valid), 32'h0);
        check("cs_off_bcd", 32'(bus.bcd), 32'h9765);
        bus.cs = 1'b1;
        drive(7'h79, 4'h1, 8);
        drive(7'h33, 4'h2, 8);
        drive(7'h5B, 4'h4, 8);
        drive(7'h5F, 4'h8, 8, 1'b1, 16'h6543, 1'b0);
        drive(7'h00, 4'h0, 4);
        idle_cycles(1);
        check("cs_frames", 32'(nframes), 32'd5);
        check("cs_bcd", 32'(bus.bcd), 32'h6543);

        // reset mid-frame
        drive(7'h7E, 4'h1, 8);
        drive(7'h30, 4'h2, 8);
        drive(7'h6D, 4'h4, 8);
        rst = 1'b1;
        idle_cycles(2);
        rst = 1'b0;
        check("midrst_bcd", 32'(bus.bcd), 32'h0);
        check("midrst_err", 32'(bus.seg_err), 32'h0);
        drive(7'h79, 4'h8, 8);
        drive(7'h00, 4'h0, 10);
        idle_cycles(1);
        check("final_bcd", 32'(bus.bcd), 32'h0);
        check("final_frames", 32'(nframes), 32'd5);
        check("pending_frames", 32'(sbq.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
